// File: rtl/addsub_seq_pkg.sv
//------------------------------------------------------------------------------
// addsub_seq_pkg : shared types and constants for the nibble-serial add/sub
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package addsub_seq_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

`default_nettype wire

// File: rtl/addsub_seq_ctrl_addsub.sv
//------------------------------------------------------------------------------
// addsub : combinational 4-bit adder/subtractor with carry/borrow in and out
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub
   import addsub_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                xin,
   input  logic                op,
   output logic [NIBBLE_W-1:0] s_d,
   output logic                co_bo
);

   logic [NIBBLE_W:0] w_sum;

   // Bit 4 of the 5-bit difference is set exactly when a < b + xin.
   always_comb begin
      w_sum = '0;
      if (op == OP_SUB)
         w_sum = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, xin};
      else
         w_sum = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, xin};
   end

   assign s_d   = w_sum[NIBBLE_W-1:0];
   assign co_bo = w_sum[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
//------------------------------------------------------------------------------
// addsub_seq_ctrl : multi-precision add/sub sequencer over one 4-bit addsub.
// Optional signed-overflow output enabled by ADDSUB_SEQ_OVF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module addsub_seq_ctrl
   import addsub_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_valid,
   output logic                          start_ready,
   input  logic                          op_in,
   input  logic [NIBBLES*NIBBLE_W-1:0]   a_in,
   input  logic [NIBBLES*NIBBLE_W-1:0]   b_in,
   output logic                          busy,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [NIBBLES*NIBBLE_W-1:0]   res,
`ifdef ADDSUB_SEQ_OVF_EN
   output logic                          ovf,
`endif
   output logic                          co_bo_out
);

   localparam int W     = NIBBLES * NIBBLE_W;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   seq_state_t          r_state;
   seq_state_t          w_next_state;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic                r_op;
   logic                r_carry;
   logic [IDX_W-1:0]    r_idx;
   logic [W-1:0]        w_a_sh;
   logic [W-1:0]        w_b_sh;
   logic [NIBBLE_W-1:0] w_s_d;
   logic                w_co_bo;
   logic                w_last;
   logic                w_accept;

   assign w_a_sh   = r_a >> (32'(r_idx) * NIBBLE_W);
   assign w_b_sh   = r_b >> (32'(r_idx) * NIBBLE_W);
   assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
   assign w_accept = (r_state == IDLE) && start_valid;

   addsub u_addsub (
      .a     (w_a_sh[NIBBLE_W-1:0]),
      .b     (w_b_sh[NIBBLE_W-1:0]),
      .xin   (r_carry),
      .op    (r_op),
      .s_d   (w_s_d),
      .co_bo (w_co_bo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      start_ready  = 1'b0;
      busy         = 1'b0;
      res_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) w_next_state = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next_state = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= OP_ADD;
         r_carry   <= 1'b0;
         r_idx     <= '0;
         res       <= '0;
         co_bo_out <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_in;
         r_b     <= b_in;
         r_op    <= op_in;
         r_carry <= 1'b0;
         r_idx   <= '0;
         res     <= '0;
      end else if (r_state == RUN) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) res[i*NIBBLE_W +: NIBBLE_W] <= w_s_d;
         end
         r_carry <= w_co_bo;
         r_idx   <= r_idx + IDX_W'(1);
         if (w_last) co_bo_out <= w_co_bo;
      end
   end

`ifdef ADDSUB_SEQ_OVF_EN
   logic w_a_sgn;
   logic w_b_sgn;
   logic w_r_sgn;
   logic w_ovf;

   // Subtraction overflows when operand signs differ; addition when they match.
   assign w_a_sgn = w_a_sh[NIBBLE_W-1];
   assign w_b_sgn = w_b_sh[NIBBLE_W-1];
   assign w_r_sgn = w_s_d[NIBBLE_W-1];
   assign w_ovf   = (r_op == OP_SUB) ? ((w_a_sgn ^ w_b_sgn) & (w_r_sgn ^ w_a_sgn))
                                     : (~(w_a_sgn ^ w_b_sgn) & (w_r_sgn ^ w_a_sgn));

   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if ((r_state == RUN) && w_last)
         ovf <= w_ovf;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
//------------------------------------------------------------------------------
// tb_addsub_seq_ctrl : directed self-checking bench for addsub_seq_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub_seq_ctrl;
   localparam int NIB = 4;
   localparam int W   = NIB * 4;

   logic         clk         = 1'b0;
   logic         rst_n       = 1'b0;
   logic         start_valid = 1'b0;
   logic         op_in       = 1'b0;
   logic         res_ready   = 1'b0;
   logic [W-1:0] a_in        = '0;
   logic [W-1:0] b_in        = '0;
   logic         start_ready;
   logic         busy;
   logic         res_valid;
   logic         co_bo_out;
   logic [W-1:0] res;
`ifdef ADDSUB_SEQ_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;
   int lat;

   addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_in       (op_in),
      .a_in        (a_in),
      .b_in        (b_in),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res         (res),
`ifdef ADDSUB_SEQ_OVF_EN
      .ovf         (ovf),
`endif
      .co_bo_out   (co_bo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_job(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op_in       = op;
      a_in        = a;
      b_in        = b;
      start_valid = 1'b1;
      check("start_ready_before_accept", 32'(start_ready), 32'd1);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
   endtask

   task automatic wait_result(output int cycles);
      cycles = 0;
      while (!res_valid && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic expect_result(input string tag, input logic [W-1:0] exp_res, input logic exp_co);
      int l;
      wait_result(l);
      check({tag, "_latency"}, 32'(l), 32'd4);
      check({tag, "_res"}, 32'(res), 32'(exp_res));
      check({tag, "_co_bo"}, 32'(co_bo_out), 32'(exp_co));
   endtask

   task automatic release_result();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("release_start_ready", 32'(start_ready), 32'd1);
      check("release_res_valid", 32'(res_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_res", 32'(res), 32'd0);
      check("rst_co_bo", 32'(co_bo_out), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start_ready", 32'(start_ready), 32'd1);
`ifdef ADDSUB_SEQ_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // res_ready held high throughout: must not shorten RUN
      res_ready = 1'b1;
      start_job(1'b0, 16'h1234, 16'h0FFF);
      check("add1_busy", 32'(busy), 32'd1);
      expect_result("add1", 16'h2233, 1'b0);
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("add1_exit_valid", 32'(res_valid), 32'd0);
      check("add1_exit_ready", 32'(start_ready), 32'd1);
      check("add1_res_hold", 32'(res), 32'h2233);

      start_job(1'b0, 16'hFFFF, 16'h0001);
      expect_result("add_wrap", 16'h0000, 1'b1);
      release_result();

`ifdef ADDSUB_SEQ_OVF_EN
      start_job(1'b0, 16'h7FFF, 16'h0001);
      expect_result("add_ovf", 16'h8000, 1'b0);
      check("add_ovf_flag", 32'(ovf), 32'd1);
      release_result();
`endif

      start_job(1'b1, 16'h1000, 16'h0001);
      expect_result("sub1", 16'h0FFF, 1'b0);
      release_result();

      start_job(1'b1, 16'h0001, 16'h0002);
      expect_result("sub_borrow", 16'hFFFF, 1'b1);
`ifdef ADDSUB_SEQ_OVF_EN
      check("sub_borrow_ovf", 32'(ovf), 32'd0);
`endif
      release_result();

      // backpressure with a competing request that must not be taken
      start_job(1'b0, 16'h00AB, 16'h0011);
      expect_result("bp", 16'h00BC, 1'b0);
      @(negedge clk);
      start_valid = 1'b1;
      a_in        = 16'hFFFF;
      b_in        = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_res_stable", 32'(res), 32'h00BC);
         check("bp_co_stable", 32'(co_bo_out), 32'd0);
         check("bp_start_ready", 32'(start_ready), 32'd0);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
      start_valid = 1'b0;
      release_result();
      check("bp_after_res", 32'(res), 32'h00BC);
      check("bp_after_busy", 32'(busy), 32'd0);

      // reset while RUN is on nibble 2
      start_job(1'b0, 16'h1111, 16'h2222);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_start_ready", 32'(start_ready), 32'd1);
      check("midrst_res", 32'(res), 32'd0);
      check("midrst_res_valid", 32'(res_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      start_job(1'b0, 16'h0003, 16'h0004);
      expect_result("post_rst", 16'h0007, 1'b0);
      release_result();

      // back-to-back: second job queued with start_valid held through job 1
      start_job(1'b0, 16'h5555, 16'h1111);
      start_valid = 1'b1;
      op_in       = 1'b1;
      a_in        = 16'h0010;
      b_in        = 16'h0020;
      expect_result("b2b_first", 16'h6666, 1'b0);
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("b2b_idle_ready", 32'(start_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b_second_accept", 32'(busy), 32'd1);
      start_valid = 1'b0;
      wait_result(lat);
      check("b2b_second_latency", 32'(lat), 32'd4);
      check("b2b_second_res", 32'(res), 32'hFFF0);
      check("b2b_second_co_bo", 32'(co_bo_out), 32'd1);
`ifdef ADDSUB_SEQ_OVF_EN
      check("b2b_second_ovf", 32'(ovf), 32'd0);
`endif
      release_result();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Multi-precision sequencer that reuses one 4-bit `addsub` datapath instance, nibble-serially, to add or subtract NIBBLES*4-bit operands.
- Accepts a job on a valid/ready handshake and walks the nibbles LSB-first, feeding each nibble's carry/borrow out into the next nibble's xin.
- Returns the full result plus the final carry/borrow on a second valid/ready handshake.
- Sits between a command source (test sequencer or CPU-style front end) and the shared 4-bit add/sub datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  controller can accept a job.
- op_in  in  1  0 = add, 1 = subtract.
- a_in  in  W  operand A, unsigned.
- b_in  in  W  operand B, unsigned.
- busy  out  1  high in RUN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res  out  W  sum or difference.
- co_bo_out  out  1  final carry (add) or borrow (subtract).

Behaviour:
- Datapath contract for the `addsub` instance, which is combinational:
  - op=0: {co_bo, s_d} = a + b + xin.
  - op=1: s_d = (a - b - xin) mod 16; co_bo = 1 iff a < b + xin.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - res, co_bo_out, res_valid and busy are all 0; start_ready is 1 after reset.
  - The nibble index and the carry register clear to 0.
  - Reset takes priority over everything, including mid-RUN; a job that is interrupted is dropped with no output.
- State machine (enum IDLE, RUN, DONE):
  - IDLE: start_ready=1. On start_valid&&start_ready at edge t:
    - latch a_in, b_in and op_in;
    - clear the carry register and idx;
    - clear the res register;
    - go to RUN.
  - RUN: start_ready=0 and busy=1. Each cycle the datapath sees a=A[idx*4+:4], b=B[idx*4+:4], xin=carry and op=latched op. At each edge:
    - res[idx*4+:4] <= s_d;
    - carry <= co_bo;
    - idx <= idx+1.
    - When idx==NIBBLES-1: co_bo_out <= co_bo and the state goes to DONE.
  - DONE: res_valid=1; res and co_bo_out are held stable. On res_ready at an edge, go to IDLE and drop res_valid. res keeps its value until the next accept.
- Latency: accept at edge t, last nibble at edge t+NIBBLES, res_valid high from cycle t+NIBBLES through the res_ready edge. Minimum job-to-job spacing is NIBBLES+2 cycles.
- While busy or in DONE, start_valid is ignored and not acknowledged. Operands presented during that time are not sampled.
- Wrap-around:
  - Add overflow past 2^W wraps the result modulo 2^W and sets co_bo_out=1.
  - Subtract with A<B gives (A-B) mod 2^W and sets co_bo_out=1.
- NIBBLES=1: RUN lasts exactly one cycle.
- A res_ready held high before DONE causes no early exit. It is only sampled in DONE.

Optional Feature:
- Macro: ADDSUB_SEQ_OVF_EN.
- With the macro defined:
  - extra output port ovf (out, 1) gives signed two's-complement overflow of the whole W-bit operation, registered alongside co_bo_out;
  - the overflow rule is carry-into-MSB XOR carry-out-of-MSB, computed on the top nibble using the latched operand sign bits and the result sign bit;
  - ovf=0 on reset;
  - ovf is valid and held whenever res_valid=1.
- Without the macro: no ovf port, logic or register.

Decomposition:
- Package addsub_seq_pkg holds:
  - NIBBLE_W=4;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  - localparams OP_ADD=1'b0 and OP_SUB=1'b1.
- The one natural sub-module is the existing `addsub`, instantiated once. All sequencing, muxing and registers live in addsub_seq_ctrl.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FFF, res_ready=1 -> res=0x2233, co_bo_out=0, res_valid exactly 4 cycles after accept.
- Add 0xFFFF+0x0001 -> res=0x0000, co_bo_out=1. With OVF_EN: 0x7FFF+0x0001 -> res=0x8000, ovf=1.
- Subtract 0x1000-0x0001 -> res=0x0FFF, co_bo_out=0. Subtract 0x0001-0x0002 -> res=0xFFFF, co_bo_out=1, ovf=0.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res and co_bo_out stable, start_ready=0, a new start_valid is not accepted. After the res_ready pulse -> IDLE next cycle.
- Reset mid-job: rst_n=0 during RUN idx=2 -> next cycle IDLE, res=0, res_valid=0, start_ready=1. A subsequent add 0x0003+0x0004 -> 0x0007.
- Back-to-back: start_valid held high with a second job queued -> second accept exactly one cycle after the first res_ready edge, with correct independent result.
